// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier with start/done handshake and per-operation signed mode.
// Optional macro SEQ_MULT_EARLY_TERM_EN leaves RUN as soon as the remaining multiplier bits are zero.
module seq_multiplier #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 overflow
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StSign = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic                 signed_q, signed_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 overflow_q, overflow_d;

   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [2*WIDTH-1:0]   signed_prod;
   logic [WIDTH:0]       sign_bits;
   logic                 early_exit;

   // Magnitudes are held unsigned, so the most-negative operand still multiplies correctly.
   assign a_mag = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
   assign b_mag = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;

   assign signed_prod = neg_q ? -prod_q : prod_q;
   assign sign_bits   = signed_prod[2*WIDTH-1:WIDTH-1];

`ifdef SEQ_MULT_EARLY_TERM_EN
   assign early_exit = (mplier_q == '0);
`else
   assign early_exit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      prod_d     = prod_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      signed_d   = signed_q;
      result_d   = result_q;
      overflow_d = overflow_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               neg_d    = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
               signed_d = signed_mode;
               prod_d   = '0;
               cnt_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            if (early_exit || (cnt_q == CNT_W'(WIDTH))) begin
               state_d = StSign;
            end else begin
               if (mplier_q[0]) begin
                  prod_d = prod_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
            end
         end
         StSign: begin
            result_d = signed_prod;
            if (signed_q) begin
               overflow_d = !((&sign_bits) || !(|sign_bits));
            end else begin
               overflow_d = |signed_prod[2*WIDTH-1:WIDTH];
            end
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         mcand_q    <= '0;
         mplier_q   <= '0;
         prod_q     <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         signed_q   <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         prod_q     <= prod_d;
         cnt_q      <= cnt_d;
         neg_q      <= neg_d;
         signed_q   <= signed_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy     = (state_q == StRun) || (state_q == StSign);
   assign done     = (state_q == StDone);
   assign result   = result_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8: vector table plus ignored-start and mid-run reset.
module tb_seq_multiplier;

   localparam int W = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            signed_mode;
   logic [W-1:0]    multiplicand;
   logic [W-1:0]    multiplier;
   logic            busy;
   logic            done;
   logic [2*W-1:0]  result;
   logic            overflow;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .signed_mode  (signed_mode),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .overflow     (overflow)
   );

   typedef struct {
      logic          sm;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [2*W-1:0] res;
      logic          ovf;
      int            lat_early;  // done cycle offset from N when early termination is built in
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int lat_of(input int lat_early);
`ifdef SEQ_MULT_EARLY_TERM_EN
      return lat_early;
`else
      return W + 2;
`endif
   endfunction

   // Accepts one operation, then scrambles the inputs and watches 16 cycles (index 0 = cycle N).
   task automatic run_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, output int done_at, output int ndone,
                         output int busy_bad);
      @(negedge clk);
      start = 1'b1; signed_mode = sm; multiplicand = a; multiplier = b;
      @(negedge clk);
      start = 1'b0; signed_mode = ~sm; multiplicand = ~a; multiplier = ~b;
      done_at = -1; ndone = 0; busy_bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = i;
         end
         if (busy !== (i < exp_lat)) busy_bad++;
         @(negedge clk);
      end
   endtask

   initial begin
      int done_at, ndone, busy_bad, lat;

      vecs[0]  = '{1'b0, 8'd13,  8'd11,  16'h008F, 1'b0, 6};
      vecs[1]  = '{1'b1, 8'hFD,  8'h05,  16'hFFF1, 1'b0, 5};
      vecs[2]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01, 1'b1, 10};
      vecs[3]  = '{1'b1, 8'h80,  8'h80,  16'h4000, 1'b1, 10};
      vecs[4]  = '{1'b1, 8'h80,  8'h01,  16'hFF80, 1'b0, 3};
      vecs[5]  = '{1'b0, 8'd200, 8'h01,  16'h00C8, 1'b0, 3};
      vecs[6]  = '{1'b0, 8'd200, 8'h00,  16'h0000, 1'b0, 2};
      vecs[7]  = '{1'b0, 8'd6,   8'd7,   16'h002A, 1'b0, 5};
      vecs[8]  = '{1'b1, 8'h7F,  8'h7F,  16'h3F01, 1'b1, 9};
      vecs[9]  = '{1'b1, 8'hFF,  8'hFF,  16'h0001, 1'b0, 3};
      vecs[10] = '{1'b1, 8'h05,  8'hFE,  16'hFFF6, 1'b0, 4};
      vecs[11] = '{1'b0, 8'h10,  8'h10,  16'h0100, 1'b1, 7};

      reset = 1'b1; start = 1'b0; signed_mode = 1'b0; multiplicand = '0; multiplier = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_result", 64'(result), 64'd0);
      check("reset_overflow", 64'(overflow), 64'd0);
      reset = 1'b0;

      for (int v = 0; v < 12; v++) begin
         lat = lat_of(vecs[v].lat_early);
         run_op(vecs[v].sm, vecs[v].a, vecs[v].b, lat, done_at, ndone, busy_bad);
         check($sformatf("v%0d_result", v), 64'(result), 64'(vecs[v].res));
         check($sformatf("v%0d_overflow", v), 64'(overflow), 64'(vecs[v].ovf));
         check($sformatf("v%0d_done_cycle", v), 64'(done_at), 64'(lat));
         check($sformatf("v%0d_done_count", v), 64'(ndone), 64'd1);
         check($sformatf("v%0d_busy_window_errs", v), 64'(busy_bad), 64'd0);
      end

      // Start pulses mid-RUN and during DONE must both be ignored.
      lat = lat_of(6);
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; multiplicand = 8'd13; multiplier = 8'd11;
      @(negedge clk);
      start = 1'b0; multiplicand = 8'd2; multiplier = 8'd2;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) ndone++;
         start = (i == 3) || (i == lat);
         @(negedge clk);
      end
      start = 1'b0;
      check("ignore_start_result", 64'(result), 64'h008F);
      check("ignore_start_done_count", 64'(ndone), 64'd1);
      check("ignore_start_no_restart", 64'(busy), 64'd0);

      // Reset sampled on the 4th RUN edge abandons the operation.
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; multiplicand = 8'd13; multiplier = 8'd11;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_busy", 64'(busy), 64'd0);
      check("midreset_done", 64'(done), 64'd0);
      check("midreset_result", 64'(result), 64'd0);
      check("midreset_overflow", 64'(overflow), 64'd0);
      ndone = 0;
      for (int i = 0; i < 14; i++) begin
         if (done || busy) ndone++;
         @(negedge clk);
      end
      check("midreset_no_activity", 64'(ndone), 64'd0);
      lat = lat_of(5);
      run_op(1'b0, 8'd6, 8'd7, lat, done_at, ndone, busy_bad);
      check("after_reset_result", 64'(result), 64'h002A);
      check("after_reset_done_cycle", 64'(done_at), 64'(lat));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
